// File: rtl/seg_counter_display_if.sv
// Control and display signals of seg_counter_display, grouped as one bus.
// The master side drives the switch-level controls; the slave side is the counter.
interface seg_counter_display_if #(
   parameter int DIGITS = 2
);
   logic                  input_enable;
   logic                  input_up;
   logic                  input_load;
   logic [4*DIGITS-1:0]   input_load_value;
   logic [4*DIGITS-1:0]   output_count;
   logic [8*DIGITS-1:0]   output_segments;
   logic                  output_terminal;

   modport master (
      output input_enable,
      output input_up,
      output input_load,
      output input_load_value,
      input  output_count,
      input  output_segments,
      input  output_terminal
   );

   modport slave (
      input  input_enable,
      input  input_up,
      input  input_load,
      input  input_load_value,
      output output_count,
      output output_segments,
      output output_terminal
   );
endinterface

// File: rtl/seg_counter_display.sv
// Synchronous N-digit BCD/hex up/down counter with prescaler, parallel load and 7-segment decode.
// Optional leading-zero blanking is enabled by defining SEG_COUNTER_LEADING_ZERO_BLANK_EN.
module seg_counter_display #(
   parameter int DIGITS   = 2,
   parameter int HEX_MODE = 0,
   parameter int PRESCALE = 1
) (
   input logic                  input_clock,
   input logic                  input_reset,
   seg_counter_display_if.slave bus
);
   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);
   localparam logic [3:0]    DMAX     = (HEX_MODE != 0) ? 4'hF : 4'h9;
   localparam int            CW       = 4 * DIGITS;

   logic [CW-1:0]       count;
   logic [PW-1:0]       presc;
   logic                terminal;
   logic [CW-1:0]       step_count;
   logic [CW-1:0]       load_count;
   logic                wrap;
   logic [8*DIGITS-1:0] segments;

   // Bit order: 0 g, 1 f, 2 e, 3 d, 4 a, 5 b, 6 dp, 7 c (dp never lit).
   function automatic logic [7:0] decode7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'h0: s = 8'hBE;
         4'h1: s = 8'hA0;
         4'h2: s = 8'h3D;
         4'h3: s = 8'hB9;
         4'h4: s = 8'hA3;
         4'h5: s = 8'h9B;
         4'h6: s = 8'h9F;
         4'h7: s = 8'hB0;
         4'h8: s = 8'hBF;
         4'h9: s = 8'hBB;
         4'hA: s = 8'hB7;
         4'hB: s = 8'h8F;
         4'hC: s = 8'h1E;
         4'hD: s = 8'hAD;
         4'hE: s = 8'h1F;
         default: s = 8'h17;
      endcase
      if (HEX_MODE == 0 && d > 4'h9) s = 8'h00;
      return s;
   endfunction

   function automatic logic [3:0] fold_digit(input logic [3:0] d);
      return (HEX_MODE == 0 && d > 4'h9) ? 4'h0 : d;
   endfunction

   always_comb begin
      load_count = bus.input_load_value;
      for (int k = 0; k < DIGITS; k++)
         load_count[4*k +: 4] = fold_digit(bus.input_load_value[4*k +: 4]);
   end

   // Ripple carry/borrow across all digits in one cycle; a carry out of the top is a wrap.
   always_comb begin
      logic       carry;
      logic [3:0] d;
      carry      = 1'b1;
      d          = 4'h0;
      step_count = count;
      for (int k = 0; k < DIGITS; k++) begin
         d = count[4*k +: 4];
         if (carry) begin
            if (bus.input_up) begin
               if (d == DMAX) begin
                  step_count[4*k +: 4] = 4'h0;
               end else begin
                  step_count[4*k +: 4] = d + 4'h1;
                  carry = 1'b0;
               end
            end else begin
               if (d == 4'h0) begin
                  step_count[4*k +: 4] = DMAX;
               end else begin
                  step_count[4*k +: 4] = d - 4'h1;
                  carry = 1'b0;
               end
            end
         end
      end
      wrap = carry;
   end

   always_ff @(posedge input_clock) begin
      if (input_reset) begin
         count    <= '0;
         presc    <= '0;
         terminal <= 1'b0;
      end else if (bus.input_load) begin
         count    <= load_count;
         presc    <= '0;
         terminal <= 1'b0;
      end else begin
         terminal <= 1'b0;
         if (bus.input_enable) begin
            if (presc == PRE_LAST) begin
               presc    <= '0;
               count    <= step_count;
               terminal <= wrap;
            end else begin
               presc <= presc + PRE_ONE;
            end
         end
      end
   end

`ifdef SEG_COUNTER_LEADING_ZERO_BLANK_EN
   // Scan from the top digit; zeros above the highest nonzero digit go dark, digit 0 never does.
   always_comb begin
      logic lead;
      lead     = 1'b1;
      segments = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (count[4*k +: 4] != 4'h0) lead = 1'b0;
         if (lead && k != 0) segments[8*k +: 8] = 8'h00;
         else segments[8*k +: 8] = decode7(count[4*k +: 4]);
      end
   end
`else
   always_comb begin
      segments = '0;
      for (int k = 0; k < DIGITS; k++)
         segments[8*k +: 8] = decode7(count[4*k +: 4]);
   end
`endif

   assign bus.output_count    = count;
   assign bus.output_segments = segments;
   assign bus.output_terminal = terminal;
endmodule

// File: tb/tb_seg_counter_display.sv
// Directed bench for seg_counter_display: BCD/PRESCALE=1, BCD/PRESCALE=4 and HEX/PRESCALE=1 instances.
module tb_seg_counter_display;
`ifdef SEG_COUNTER_LEADING_ZERO_BLANK_EN
   localparam logic [7:0] ZH = 8'h00;
`else
   localparam logic [7:0] ZH = 8'hBE;
`endif

   logic clk;
   logic ra, rp, rh;
   int   n_cmp;
   int   n_err;

   seg_counter_display_if #(.DIGITS(2)) ia ();
   seg_counter_display_if #(.DIGITS(2)) ip ();
   seg_counter_display_if #(.DIGITS(2)) ih ();

   seg_counter_display #(.DIGITS(2), .HEX_MODE(0), .PRESCALE(1)) u_bcd (
      .input_clock(clk), .input_reset(ra), .bus(ia));
   seg_counter_display #(.DIGITS(2), .HEX_MODE(0), .PRESCALE(4)) u_pre (
      .input_clock(clk), .input_reset(rp), .bus(ip));
   seg_counter_display #(.DIGITS(2), .HEX_MODE(1), .PRESCALE(1)) u_hex (
      .input_clock(clk), .input_reset(rh), .bus(ih));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      ra = 1'b1; rp = 1'b1; rh = 1'b1;
      ia.input_enable = 1'b0; ia.input_up = 1'b1; ia.input_load = 1'b0; ia.input_load_value = 8'h00;
      ip.input_enable = 1'b0; ip.input_up = 1'b1; ip.input_load = 1'b0; ip.input_load_value = 8'h00;
      ih.input_enable = 1'b0; ih.input_up = 1'b1; ih.input_load = 1'b0; ih.input_load_value = 8'h00;

      // reset state
      tick(); tick();
      check_value("rst_count",    ia.output_count, 8'h00);
      check_value("rst_segs",     ia.output_segments, {ZH, 8'hBE});
      check_value("rst_term",     ia.output_terminal, 1'b0);
      check_value("rst_pre_count", ip.output_count, 8'h00);
      check_value("rst_hex_segs", ih.output_segments, {ZH, 8'hBE});
      ra = 1'b0; rp = 1'b0; rh = 1'b0;

      // BCD up through wrap
      ia.input_load = 1'b1; ia.input_load_value = 8'h98; ia.input_enable = 1'b1; ia.input_up = 1'b1;
      tick();
      check_value("load98_count", ia.output_count, 8'h98);
      check_value("load98_segs",  ia.output_segments, 16'hBBBF);
      check_value("load98_term",  ia.output_terminal, 1'b0);
      ia.input_load = 1'b0;
      tick();
      check_value("up99_count", ia.output_count, 8'h99);
      check_value("up99_segs",  ia.output_segments, 16'hBBBB);
      check_value("up99_term",  ia.output_terminal, 1'b0);
      tick();
      check_value("wrap_up_count", ia.output_count, 8'h00);
      check_value("wrap_up_term",  ia.output_terminal, 1'b1);
      check_value("wrap_up_segs",  ia.output_segments, {ZH, 8'hBE});
      ia.input_enable = 1'b0;
      tick();
      check_value("hold_count", ia.output_count, 8'h00);
      check_value("term_one_cycle", ia.output_terminal, 1'b0);

      // BCD down through wrap
      ia.input_up = 1'b0; ia.input_enable = 1'b1;
      tick();
      check_value("wrap_dn_count", ia.output_count, 8'h99);
      check_value("wrap_dn_term",  ia.output_terminal, 1'b1);
      tick();
      check_value("dn98_count", ia.output_count, 8'h98);
      check_value("dn98_term",  ia.output_terminal, 1'b0);
      ia.input_enable = 1'b0;

      // carry and borrow between digits
      ia.input_load = 1'b1; ia.input_load_value = 8'h19;
      tick();
      ia.input_load = 1'b0; ia.input_up = 1'b1; ia.input_enable = 1'b1;
      tick();
      check_value("carry20_count", ia.output_count, 8'h20);
      check_value("carry20_segs",  ia.output_segments, 16'h3DBE);
      check_value("carry20_term",  ia.output_terminal, 1'b0);
      ia.input_up = 1'b0;
      tick();
      check_value("borrow19_count", ia.output_count, 8'h19);
      ia.input_enable = 1'b0;

      // BCD load folding of invalid digits
      ia.input_load = 1'b1; ia.input_load_value = 8'hA3;
      tick();
      check_value("fold_a3_count", ia.output_count, 8'h03);
      check_value("fold_a3_segs",  ia.output_segments, {ZH, 8'hB9});
      ia.input_load_value = 8'h3A;
      tick();
      check_value("fold_3a_count", ia.output_count, 8'h30);

      // reset beats load and step
      ia.input_load_value = 8'h41;
      tick();
      ia.input_load = 1'b0; ia.input_enable = 1'b1; ia.input_up = 1'b1;
      tick();
      check_value("mid_count", ia.output_count, 8'h42);
      ra = 1'b1; ia.input_load = 1'b1; ia.input_load_value = 8'h77;
      tick();
      check_value("rst_load_count", ia.output_count, 8'h00);
      check_value("rst_load_term",  ia.output_terminal, 1'b0);
      ra = 1'b0; ia.input_load_value = 8'h99; ia.input_enable = 1'b0;
      tick();
      ia.input_load = 1'b0; ia.input_enable = 1'b1; ra = 1'b1;
      tick();
      check_value("rst_wrap_count", ia.output_count, 8'h00);
      check_value("rst_wrap_term",  ia.output_terminal, 1'b0);
      ra = 1'b0; ia.input_enable = 1'b0;

      // segment display with and without leading zeros
      ia.input_load = 1'b1; ia.input_load_value = 8'h05;
      tick();
      check_value("seg05", ia.output_segments, {ZH, 8'h9B});
      ia.input_load_value = 8'h70;
      tick();
      check_value("seg70", ia.output_segments, 16'hB0BE);
      ia.input_load_value = 8'h64;
      tick();
      check_value("seg64", ia.output_segments, 16'h9FA3);
      ia.input_load = 1'b0;

      // prescaler of 4 with enable gating and mid-prescale direction change
      ip.input_enable = 1'b1; ip.input_up = 1'b1;
      tick(); tick(); tick();
      check_value("pre_3cyc", ip.output_count, 8'h00);
      tick();
      check_value("pre_4cyc", ip.output_count, 8'h01);
      ip.input_enable = 1'b0;
      tick();
      check_value("pre_dis1", ip.output_count, 8'h01);
      tick(); tick();
      check_value("pre_dis3", ip.output_count, 8'h01);
      ip.input_enable = 1'b1; ip.input_up = 1'b0;
      tick(); tick(); tick();
      check_value("pre_mid_dir", ip.output_count, 8'h01);
      ip.input_up = 1'b1;
      tick();
      check_value("pre_step2", ip.output_count, 8'h02);
      check_value("pre_term",  ip.output_terminal, 1'b0);
      tick(); tick();
      ip.input_load = 1'b1; ip.input_load_value = 8'h10;
      tick();
      ip.input_load = 1'b0;
      tick(); tick(); tick();
      check_value("pre_load_clr", ip.output_count, 8'h10);
      tick();
      check_value("pre_after_load", ip.output_count, 8'h11);
      ip.input_enable = 1'b0;

      // hex mode
      ih.input_load = 1'b1; ih.input_load_value = 8'hFF; ih.input_enable = 1'b1; ih.input_up = 1'b1;
      tick();
      check_value("hex_ff_count", ih.output_count, 8'hFF);
      check_value("hex_ff_segs",  ih.output_segments, 16'h1717);
      ih.input_load = 1'b0;
      tick();
      check_value("hex_wrap_count", ih.output_count, 8'h00);
      check_value("hex_wrap_term",  ih.output_terminal, 1'b1);
      ih.input_load = 1'b1; ih.input_load_value = 8'h0F;
      tick();
      check_value("hex_0f_count", ih.output_count, 8'h0F);
      check_value("hex_0f_segs",  ih.output_segments, {ZH, 8'h17});
      check_value("hex_0f_term",  ih.output_terminal, 1'b0);
      ih.input_load = 1'b0;
      tick();
      check_value("hex_carry_count", ih.output_count, 8'h10);
      check_value("hex_carry_segs",  ih.output_segments, 16'hA0BE);
      ih.input_load = 1'b1; ih.input_load_value = 8'h09;
      tick();
      ih.input_load = 1'b0;
      tick();
      check_value("hex_0a_count", ih.output_count, 8'h0A);
      check_value("hex_0a_segs",  ih.output_segments, {ZH, 8'hB7});
      ih.input_load = 1'b1; ih.input_load_value = 8'h00;
      tick();
      ih.input_load = 1'b0; ih.input_up = 1'b0;
      tick();
      check_value("hex_dn_count", ih.output_count, 8'hFF);
      check_value("hex_dn_term",  ih.output_terminal, 1'b1);
      ih.input_enable = 1'b0; ih.input_load = 1'b1; ih.input_load_value = 8'hBC;
      tick();
      check_value("hex_bc_segs", ih.output_segments, 16'h8F1E);
      ih.input_load_value = 8'hDE;
      tick();
      check_value("hex_de_segs", ih.output_segments, 16'hAD1F);
      ih.input_load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/seg_counter_display.md
Name: seg_counter_display

Overview:
- Parametrised synchronous N-digit counter with built-in 7-segment decode per digit.
- Supersedes the hard-wired ripple JK-chain counter and display sub-ICs with a single-clock, fully synchronous block.
- Adds up/down counting, parallel load, enable, prescaler, BCD or hex radix, and a wrap indication.
- Sits between board clock/switch inputs and the 7-segment/LED outputs.

Parameters:
- DIGITS, 2, number of 4-bit digits (1..8).
- HEX_MODE, 0: 0 = BCD (each digit 0..9); 1 = hex (each digit 0..F).
- PRESCALE, 1: number of enabled clock cycles per count step (1..65535).

Ports:
- input_clock  in  1  single clock; all state updates on its rising edge.
- input_reset  in  1  synchronous, active-high reset.
- input_enable  in  1  count enable; also gates the prescaler.
- input_up  in  1  direction: 1 = up, 0 = down; sampled on the step cycle.
- input_load  in  1  synchronous parallel load.
- input_load_value  in  4*DIGITS  load data; digit k is bits [4k+3:4k].
- output_count  out  4*DIGITS  current count; digit k is bits [4k+3:4k], registered.
- output_segments  out  8*DIGITS  active-high segments for digit k in bits [8k+7:8k], ordered bit0 g, bit1 f, bit2 e, bit3 d, bit4 a, bit5 b, bit6 dp, bit7 c.
- output_terminal  out  1  registered one-cycle pulse on wrap.

Behaviour:
- Reset values:
  - count = 0; prescaler = 0; output_terminal = 0.
  - output_segments = "0" pattern (8'hBE) on every digit.
- Priority per edge: input_reset > input_load > step. Reset mid-load or mid-step wins outright.
- Load:
  - count <= input_load_value, prescaler <= 0, terminal <= 0.
  - In BCD mode any loaded digit > 9 is stored as 0.
  - Load is honoured regardless of input_enable.
- Prescaler:
  - Increments on each cycle with input_enable=1 and no load.
  - On reaching PRESCALE-1 it returns to 0 and a step occurs in that cycle.
  - PRESCALE=1 gives a step on every enabled cycle.
  - input_enable=0 freezes both the prescaler and the count.
- Step up:
  - Digit 0 increments. A digit at max (9 BCD / F hex) rolls to 0 and carries into the next digit; the carry propagates through all digits in the same cycle.
  - All digits at max rolls to all zero, and output_terminal = 1 in the cycle after that edge.
- Step down:
  - Mirror of step up with borrow. All zero rolls to all max, and output_terminal pulses.
- output_terminal is high for exactly one cycle per wrap and 0 otherwise, including consecutive non-wrapping steps.
- Latency: count and terminal change one cycle after the step/load edge. Segments are decoded combinationally from the registered count, so they have zero extra latency.
- Decode (standard active-high):
  - 0..9 standard shapes.
  - A, b, C, d, E, F in hex mode.
  - dp is always 0.
- Changing input_up mid-prescale has no effect until the step cycle; no state is corrupted.

Optional Feature:
- Macro SEG_COUNTER_LEADING_ZERO_BLANK_EN.
- Defined: every most-significant digit that is 0 and above the highest nonzero digit outputs 8'h00 on its segments. Digit 0 is never blanked. output_count is unaffected.
- Undefined: all digits are always decoded, and zeros show 8'hBE.

Test Plan:
1. DIGITS=2, BCD, PRESCALE=1; assert reset 2 cycles -> output_count=8'h00, output_segments=16'hBEBE, output_terminal=0.
2. Load 8'h98, enable=1, up=1 for 2 cycles -> count 8'h99 then 8'h00; output_terminal=1 only in the cycle count reads 8'h00; segments 16'hBBBB at 8'h99.
3. From 8'h00, up=0, enable 1 cycle -> count 8'h99 and terminal pulse; next step -> 8'h98 with terminal=0.
4. PRESCALE=4:
   - 4 enabled cycles, then enable=0 for 3 cycles, then 4 enabled cycles -> count 8'h02.
   - Count is unchanged during the disabled cycles.
5. BCD: load 8'hA3 -> count 8'h03. Hex mode (HEX_MODE=1): load 8'hFF, up step -> 8'h00 with terminal pulse; load 8'h0F -> digit0 segments show F (a,e,f,g on = 8'h17).
6. Reset and load asserted together mid-count -> count 8'h00, terminal 0. With the macro defined, count 8'h05 -> upper digit segments 8'h00, digit0 shows 5.
